if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage pipeline; feeds the decode stage through the IF/ID register.
//  Owns the PC, drives a request/ready instruction-memory port, absorbs memory wait states and decode stalls,
//  and applies jump/branch redirects resolved in decode. Inserts NOP bubbles on flush or memory stall.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0000  bubble encoding written to IFIDInstr (sll $0,$0,0)
// PORTS
//  clock            in   1   single clock; all state on posedge
//  reset_n          in   1   asynchronous, active-low reset
//  Hazard           in   1   decode load-use stall: hold PC and IF/ID
//  IFIDFlush        in   1   decode redirect (branch taken or jump)
//  IDJump           in   1   redirect is a jump
//  IDJumpTarget     in   32  jump target
//  IDNonJumpTarget  in   32  branch target (or PC+4) from decode
//  ImemReq          out  1   fetch request valid
//  ImemAddr         out  32  fetch address (= PC register)
//  ImemReady        in   1   response valid this cycle; request retires
//  ImemRdata        in   32  instruction word, valid with ImemReady
//  IFPCPlus4Out     out  32  PC+4 of current fetch PC (combinational)
//  IFIDInstr        out  32  IF/ID instruction register
//  IFIDPCPlus4      out  32  IF/ID PC+4 register
// BEHAVIOUR
//  Reset (async, reset_n=0): PC=RESET_PC, state=IDLE, IFIDInstr=NOP_INSTR, IFIDPCPlus4=0, buffer cleared,
//   drop flag=0, ImemReq=0. Mid-operation reset abandons any outstanding fetch; later stray ImemReady ignored.
//  States: IDLE -> REQ (one cycle after reset release); REQ: ImemReq=1, ImemAddr=PC held stable until ImemReady;
//   HELD: word captured while Hazard=1, ImemReq=0.
//  Redirect taken only when IFIDFlush=1 && Hazard=0; target = IDJump ? IDJumpTarget : IDNonJumpTarget.
//  Hazard=1 has priority: PC, IF/ID, buffer unchanged; IFIDFlush ignored that cycle.
//  Per cycle, Hazard=0, evaluated in priority order:
//   1 redirect: IF/ID<=NOP,PC+4 field 0; PC<=target; if REQ and no ImemReady this cycle, set drop flag
//     (outstanding fetch completes and is discarded); HELD->REQ, buffer discarded.
//   2 REQ & ImemReady & drop: discard word, clear drop, stay REQ at new PC; IF/ID<=NOP.
//   3 REQ & ImemReady: IFIDInstr<=ImemRdata, IFIDPCPlus4<=PC+4, PC<=PC+4, stay REQ (next request next cycle).
//   4 HELD: IF/ID<=buffer, PC<=PC+4, ->REQ.
//   5 REQ, no ImemReady: IF/ID<=NOP (memory bubble).
//  Hazard=1 & REQ & ImemReady (no drop): word -> buffer, ->HELD; with drop: discard, clear drop.
//  Zero-wait memory sustains 1 instr/cycle; latency ImemReady -> IFIDInstr = 1 edge.
//  PC arithmetic mod 2^32; PC+4 wraps 32'hFFFF_FFFC -> 0. PC[1:0] never checked.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs FetchCount[31:0] (instructions delivered to IF/ID, cases 3/4) and
//   StallCount[31:0] (cycles IF/ID loaded NOP for memory wait or Hazard held); both reset to 0, wrap.
//  Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Shared package if_pkg: state enum {IDLE,REQ,HELD}, NOP_INSTR, RESET_PC defaults, redirect-select function.
//  Sub-module if_fetch_ctrl: FSM + drop flag + hold buffer; top keeps PC, PC+4 adder, IF/ID register.
// TESTING
//  1 Reset, ImemReady tied 1, Rdata=addr: IFIDInstr 0,4,8,12 on consecutive edges; PCPlus4 4,8,12,16.
//  2 Ready 2 cycles late at PC=8: ImemAddr held 8 three cycles, IFIDInstr=NOP twice, then word @8.
//  3 Hazard=1 for 2 cycles, Ready=1: IF/ID and PC frozen; word @PC delivered once, no duplicate/skip.
//  4 IFIDFlush=1,IDJump=1,target 0x400 while fetch @0x10 outstanding: late word @0x10 dropped, next ImemAddr 0x400.
//  5 IFIDFlush=1 & Hazard=1 same cycle: no redirect; flush honoured when Hazard falls.
//  6 reset_n low mid-wait: ImemReq=0 immediately, IFIDInstr=NOP, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types, defaults and helpers for the instruction-fetch stage.
package if_pkg;

  localparam logic [31:0] ResetPcDefault  = 32'h0000_0000;
  localparam logic [31:0] NopInstrDefault = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHeld
  } if_state_e;

  // Per-cycle update applied to the PC and the IF/ID register.
  typedef enum logic [2:0] {
    ActNone,
    ActRedirect,
    ActDrop,
    ActBubble,
    ActLoadMem,
    ActLoadBuf
  } if_action_e;

  function automatic logic [31:0] redirect_target(input logic        jump,
                                                  input logic [31:0] jump_target,
                                                  input logic [31:0] non_jump_target);
    return jump ? jump_target : non_jump_target;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencing: request FSM, stale-response drop flag and the word buffer
// used when a response arrives while decode is stalled.
module if_fetch_ctrl
  import if_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hazard_i,
  input  logic        flush_i,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        imem_req_o,
  output if_action_e  action_o,
  output logic [31:0] hold_buf_o
);

  if_state_e   state_q, state_d;
  logic        drop_q, drop_d;
  logic        req_q, req_d;
  logic [31:0] buf_q, buf_d;
  if_action_e  action;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    buf_d   = buf_q;
    action  = ActNone;
    if (hazard_i) begin
      // Decode stall wins over any redirect; only the response path may move.
      unique case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (imem_ready_i) begin
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              buf_d   = imem_rdata_i;
              state_d = StHeld;
            end
          end
        end
        StHeld: state_d = StHeld;
        default: state_d = StIdle;
      endcase
    end else if (flush_i) begin
      action  = ActRedirect;
      state_d = StReq;
      buf_d   = '0;
      // A fetch still in flight will return a word for the old path.
      drop_d  = (state_q == StReq) && !imem_ready_i;
    end else begin
      unique case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (imem_ready_i && drop_q) begin
            drop_d = 1'b0;
            action = ActDrop;
          end else if (imem_ready_i) begin
            action = ActLoadMem;
          end else begin
            action = ActBubble;
          end
        end
        StHeld: begin
          action  = ActLoadBuf;
          state_d = StReq;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign req_d = (state_d == StReq);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
      buf_q   <= buf_d;
    end
  end

  assign imem_req_o = req_q;
  assign action_o   = action;
  assign hold_buf_o = buf_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, PC+4 adder and IF/ID register around if_fetch_ctrl.
// Optional IF_PERF_CNT_EN adds FetchCount/StallCount outputs.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = ResetPcDefault,
  parameter logic [31:0] NOP_INSTR = NopInstrDefault
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        Hazard,
  input  logic        IFIDFlush,
  input  logic        IDJump,
  input  logic [31:0] IDJumpTarget,
  input  logic [31:0] IDNonJumpTarget,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemRdata,
  output logic [31:0] IFPCPlus4Out,
  output logic [31:0] IFIDInstr,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] IFIDPCPlus4,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`else
  output logic [31:0] IFIDPCPlus4
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic [31:0] pc_plus4;
  logic [31:0] hold_buf;
  if_action_e  action;

  if_fetch_ctrl u_fetch_ctrl (
    .clk_i        (clock),
    .rst_ni       (reset_n),
    .hazard_i     (Hazard),
    .flush_i      (IFIDFlush),
    .imem_ready_i (ImemReady),
    .imem_rdata_i (ImemRdata),
    .imem_req_o   (ImemReq),
    .action_o     (action),
    .hold_buf_o   (hold_buf)
  );

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    unique case (action)
      ActRedirect: begin
        pc_d    = redirect_target(IDJump, IDJumpTarget, IDNonJumpTarget);
        instr_d = NOP_INSTR;
        pcp4_d  = '0;
      end
      ActDrop, ActBubble: begin
        instr_d = NOP_INSTR;
        pcp4_d  = '0;
      end
      ActLoadMem: begin
        pc_d    = pc_plus4;
        instr_d = ImemRdata;
        pcp4_d  = pc_plus4;
      end
      ActLoadBuf: begin
        pc_d    = pc_plus4;
        instr_d = hold_buf;
        pcp4_d  = pc_plus4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcp4_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
    end
  end

  assign ImemAddr     = pc_q;
  assign IFPCPlus4Out = pc_plus4;
  assign IFIDInstr    = instr_q;
  assign IFIDPCPlus4  = pcp4_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (action == ActLoadMem || action == ActLoadBuf) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (action == ActBubble || Hazard) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized self-checking bench for if_stage against a queue-based fetch model.
module tb_if_stage;

  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam logic [31:0] Nop   = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        Hazard = 1'b0;
  logic        IFIDFlush = 1'b0;
  logic        IDJump = 1'b0;
  logic [31:0] IDJumpTarget = '0;
  logic [31:0] IDNonJumpTarget = '0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady = 1'b0;
  logic [31:0] ImemRdata;
  logic [31:0] IFPCPlus4Out;
  logic [31:0] IFIDInstr;
  logic [31:0] IFIDPCPlus4;

  if_stage #(
    .RESET_PC  (RstPc),
    .NOP_INSTR (Nop)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .Hazard          (Hazard),
    .IFIDFlush       (IFIDFlush),
    .IDJump          (IDJump),
    .IDJumpTarget    (IDJumpTarget),
    .IDNonJumpTarget (IDNonJumpTarget),
    .ImemReq         (ImemReq),
    .ImemAddr        (ImemAddr),
    .ImemReady       (ImemReady),
    .ImemRdata       (ImemRdata),
    .IFPCPlus4Out    (IFPCPlus4Out),
    .IFIDInstr       (IFIDInstr),
    .IFIDPCPlus4     (IFIDPCPlus4)
  );

  always #5 clock = ~clock;

  // Memory returns the requested address as the instruction word.
  assign ImemRdata = ImemAddr;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: PC, IF/ID contents, whether fetching has started, a
  // pending stale response, and at most one word parked during a stall.
  logic [31:0] m_pc, m_instr, m_pcp4;
  bit          m_live, m_drop;
  logic [31:0] m_buf[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pc    = RstPc;
    m_instr = Nop;
    m_pcp4  = '0;
    m_live  = 1'b0;
    m_drop  = 1'b0;
    m_buf.delete();
  endtask

  task automatic model_edge(input logic hz, input logic fl, input logic jp,
                            input logic [31:0] jt, input logic [31:0] njt, input logic rdy);
    bit fetching;
    fetching = m_live && (m_buf.size() == 0);
    if (hz) begin
      if (fetching && rdy) begin
        if (m_drop) m_drop = 1'b0;
        else m_buf.push_back(m_pc);
      end
    end else if (fl) begin
      m_instr = Nop;
      m_pcp4  = '0;
      m_drop  = fetching && !rdy;
      m_buf.delete();
      m_pc    = jp ? jt : njt;
    end else if (fetching && rdy && m_drop) begin
      m_drop  = 1'b0;
      m_instr = Nop;
      m_pcp4  = '0;
    end else if (fetching && rdy) begin
      m_instr = m_pc;
      m_pcp4  = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
    end else if (m_buf.size() != 0) begin
      m_instr = m_buf.pop_front();
      m_pcp4  = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
    end else if (fetching) begin
      m_instr = Nop;
      m_pcp4  = '0;
    end
    m_live = 1'b1;
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic hz, input logic fl, input logic jp,
                      input logic [31:0] jt, input logic [31:0] njt, input logic rdy);
    Hazard          = hz;
    IFIDFlush       = fl;
    IDJump          = jp;
    IDJumpTarget    = jt;
    IDNonJumpTarget = njt;
    ImemReady       = rdy;
    #1;
    check("req", 32'(ImemReq), 32'(m_live && (m_buf.size() == 0)));
    check("addr", ImemAddr, m_pc);
    check("pcplus4_out", IFPCPlus4Out, m_pc + 32'd4);
    model_edge(hz, fl, jp, jt, njt, rdy);
    @(posedge clock);
    #1;
    check("ifid_instr", IFIDInstr, m_instr);
    check("ifid_pcp4", IFIDPCPlus4, m_pcp4);
    @(negedge clock);
  endtask

  // Asserts reset asynchronously mid-cycle, releases it on a falling edge.
  task automatic do_reset();
    #2;
    reset_n   = 1'b0;
    ImemReady = 1'b1;
    #1;
    check("rst_req", 32'(ImemReq), 32'd0);
    check("rst_instr", IFIDInstr, Nop);
    check("rst_pcp4", IFIDPCPlus4, 32'd0);
    check("rst_addr", ImemAddr, RstPc);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic run_ready(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=%0d exp=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        hz, fl, jp, rdy;
    logic [31:0] jt, njt;
    model_reset();

    // Zero-wait streaming; first cycle after release is idle.
    do_reset();
    run_ready(5);
    check("t1_last_instr", IFIDInstr, 32'd12);
    check("t1_last_pcp4", IFIDPCPlus4, 32'd16);

    // Two wait states at PC=8.
    do_reset();
    run_ready(3);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    check("t2_word8", IFIDInstr, 32'd8);

    // Hazard for two cycles with ready high.
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    check("t3_frozen", IFIDInstr, 32'd8);
    run_ready(2);
    check("t3_next", IFIDInstr, 32'h10);

    // Jump while fetch at 0x10 outstanding.
    do_reset();
    run_ready(5);
    step(1'b0, 1'b1, 1'b1, 32'h400, 32'h14, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    check("t4_dropped", IFIDPCPlus4, 32'd0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    check("t4_target", IFIDInstr, 32'h400);

    // Flush under hazard is ignored until hazard falls.
    step(1'b1, 1'b1, 1'b0, '0, 32'h200, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 32'h200, 1'b0);
    run_ready(2);
    check("t5_target", IFIDInstr, 32'h200);

    // PC wrap.
    step(1'b0, 1'b1, 1'b0, '0, 32'hFFFF_FFFC, 1'b1);
    run_ready(2);
    check("wrap_instr", IFIDInstr, 32'h0);
    check("wrap_pcp4", IFIDPCPlus4, 32'h4);

    // Reset in the middle of a wait.
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    do_reset();
    run_ready(3);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      hz  = ($urandom_range(0, 99) < 20);
      fl  = ($urandom_range(0, 99) < 12);
      jp  = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 99) < 65);
      jt  = $urandom() & 32'hFFFF_FFFC;
      njt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
      step(hz, fl, jp, jt, njt, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
